sw_array_ctrl: RTL and testbench

//  Upstream sequencer for the Smith-Waterman systolic PE chain.
//  - Buffers one query S (exactly N_PE symbols) and one database T (1..T_MAX symbols) from the host.
//  - Loads S into the PEs with a changeS wavefront, then streams T into PE0 with no bubbles.
//  - Watches the tail PE and returns the final local-alignment score.

---
 rtl/sw_array_if.sv | 25 ++
 rtl/sw_array_ctrl.sv | 109 ++++++++++
 tb/tb_sw_array_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sw_array_if.sv
// sw_array_if: host S/T/start handshake, PE-chain drive bus and tail taps of the SW sequencer.
interface sw_array_if #(parameter int W = 12);
  logic start;
  logic s_valid, s_ready;
  logic [1:0] s_data;
  logic t_valid, t_ready, t_last;
  logic [1:0] t_data;
  logic arr_changeS, arr_init;
  logic [1:0] arr_S, arr_T;
  logic [W-1:0] arr_MAX, arr_V, arr_F;
  logic tail_init;
  logic [W-1:0] tail_max;
  logic busy, done;
  logic [W-1:0] score;
  modport master (
    output start, s_valid, s_data, t_valid, t_data, t_last, tail_init, tail_max,
    input  s_ready, t_ready, arr_changeS, arr_S, arr_T, arr_init, arr_MAX, arr_V, arr_F,
           busy, done, score
  );
  modport slave (
    input  start, s_valid, s_data, t_valid, t_data, t_last, tail_init, tail_max,
    output s_ready, t_ready, arr_changeS, arr_S, arr_T, arr_init, arr_MAX, arr_V, arr_F,
           busy, done, score
  );
endinterface

// File: rtl/sw_array_ctrl.sv
// sw_array_ctrl: buffers query S and database T, loads S with a changeS wavefront,
// streams T into PE0 without bubbles and returns the tail PE's final score.
module sw_array_ctrl #(
  parameter int N_PE  = 8,
  parameter int T_MAX = 64,
  parameter int W     = 12
) (
  input logic clk,
  input logic rst,
  sw_array_if.slave bus
);
  localparam int SCW = $clog2(N_PE + 1);
  localparam int TCW = $clog2(T_MAX + 1);
  localparam int SIW = $clog2(N_PE);
  localparam int TIW = $clog2(T_MAX);
  typedef enum logic [2:0] {IDLE, FILL, LOAD_S, STREAM, DRAIN} state_t;
  state_t state_q, state_d;
  logic [1:0] s_buf [N_PE];
  logic [1:0] t_buf [T_MAX];
  logic [SCW-1:0] s_cnt_q, s_cnt_d;
  logic [TCW-1:0] t_cnt_q, t_cnt_d, cnt_q, cnt_d;
  logic t_closed_q, t_closed_d, seen_q, seen_d;
  logic [W-1:0] cap_q, cap_d, score_q, score_d;
  logic done_q, done_d, chg_q, chg_d, init_q, init_d;
  logic [1:0] arr_s_q, arr_s_d, arr_t_q, arr_t_d;
  logic s_acc, t_acc, s_full, tracking, tail_fall;
  assign s_full    = s_cnt_q == SCW'(N_PE);
  assign s_acc     = bus.s_valid && bus.s_ready;
  assign t_acc     = bus.t_valid && bus.t_ready;
  assign tracking  = state_q == STREAM || state_q == DRAIN;
  assign tail_fall = seen_q && !bus.tail_init;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      s_cnt_q    <= '0;
      t_cnt_q    <= '0;
      cnt_q      <= '0;
      t_closed_q <= 1'b0;
      seen_q     <= 1'b0;
      cap_q      <= '0;
      score_q    <= '0;
      done_q     <= 1'b0;
      chg_q      <= 1'b0;
      init_q     <= 1'b0;
      arr_s_q    <= '0;
      arr_t_q    <= '0;
    end else begin
      state_q    <= state_d;
      s_cnt_q    <= s_cnt_d;
      t_cnt_q    <= t_cnt_d;
      cnt_q      <= cnt_d;
      t_closed_q <= t_closed_d;
      seen_q     <= seen_d;
      cap_q      <= cap_d;
      score_q    <= score_d;
      done_q     <= done_d;
      chg_q      <= chg_d;
      init_q     <= init_d;
      arr_s_q    <= arr_s_d;
      arr_t_q    <= arr_t_d;
    end
  end
  always_ff @(posedge clk) begin
    if (s_acc) s_buf[s_cnt_q[SIW-1:0]] <= bus.s_data;
    if (t_acc) t_buf[t_cnt_q[TIW-1:0]] <= bus.t_data;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = FILL;
      FILL:    if (s_full && t_closed_q) state_d = LOAD_S;
      LOAD_S:  if (cnt_q == TCW'(N_PE - 1)) state_d = STREAM;
      STREAM:  if (cnt_q == t_cnt_q - TCW'(1)) state_d = DRAIN;
      DRAIN:   if (tail_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Buffer counters, phase counter and tail capture; t_cnt doubles as t_len once closed.
  always_comb begin
    s_cnt_d    = state_q == IDLE ? '0 : s_cnt_q + SCW'(s_acc);
    t_cnt_d    = state_q == IDLE ? '0 : t_cnt_q + TCW'(t_acc);
    t_closed_d = state_q != IDLE &&
                 (t_closed_q || (t_acc && (bus.t_last || t_cnt_q == TCW'(T_MAX - 1))));
    cnt_d      = state_d != state_q ? '0 : cnt_q + TCW'(1);
    seen_d     = state_q == IDLE ? 1'b0 : seen_q || (tracking && bus.tail_init);
    cap_d      = state_q == IDLE ? '0 : (tracking && bus.tail_init ? bus.tail_max : cap_q);
    done_d     = state_q == DRAIN && tail_fall;
    score_d    = done_d ? cap_q : score_q;
  end
  // Array drive is computed from the next state so the registered outputs line up with it.
  always_comb begin
    chg_d   = state_d == LOAD_S && cnt_d == '0;
    arr_s_d = state_d == LOAD_S ? s_buf[cnt_d[SIW-1:0]] : 2'b00;
    arr_t_d = state_d == STREAM ? t_buf[cnt_d[TIW-1:0]] : 2'b00;
    init_d  = state_d == STREAM;
  end
  assign bus.s_ready     = state_q == FILL && !s_full;
  assign bus.t_ready     = state_q == FILL && !t_closed_q;
  assign bus.arr_changeS = chg_q;
  assign bus.arr_S       = arr_s_q;
  assign bus.arr_T       = arr_t_q;
  assign bus.arr_init    = init_q;
  assign bus.arr_MAX     = '0;
  assign bus.arr_V       = '0;
  assign bus.arr_F       = W'(12'h900);
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = done_q;
  assign bus.score       = score_q;
endmodule

// File: tb/tb_sw_array_ctrl.sv
// tb_sw_array_ctrl: randomized jobs against a Smith-Waterman reference and a delayed-tail chain stand-in.
module tb_sw_array_ctrl;
  localparam int N_PE = 8, T_MAX = 64, W = 12;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  sw_array_if #(.W(W)) b ();
  sw_array_ctrl #(.N_PE(N_PE), .T_MAX(T_MAX), .W(W)) dut (.clk(clk), .rst(rst), .bus(b));
  int vectors = 0, miscompares = 0;
  bit chain_en = 0;
  logic [N_PE-1:0] pipe = '0;
  logic m_init = 1'b0;
  logic [W-1:0] m_max = '0;
  int col = 0;
  int cm [T_MAX];
  logic [1:0] sq [N_PE];
  logic [1:0] tq [T_MAX];
  logic [1:0] cap_s [$];
  logic [1:0] cap_t [$];
  int chg_cnt, first_init, last_init, done_cyc, done_cnt;
  logic [W-1:0] cap_score;
  // The chain's tail echoes arr_init N_PE cycles later and reports the running best score.
  assign b.tail_init = chain_en ? pipe[N_PE-1] : m_init;
  assign b.tail_max  = chain_en ? (col < T_MAX ? W'(cm[col]) : '0) : m_max;
  always @(posedge clk) begin
    pipe <= rst ? '0 : {pipe[N_PE-2:0], b.arr_init};
    col  <= (rst || !b.busy) ? 0 : col + (b.tail_init ? 1 : 0);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic build_model(input int tl);
    int h [N_PE+1][T_MAX+1];
    int best = 0;
    for (int i = 0; i <= N_PE; i++) for (int j = 0; j <= T_MAX; j++) h[i][j] = 0;
    for (int j = 1; j <= T_MAX; j++) begin
      if (j <= tl) for (int i = 1; i <= N_PE; i++) begin
        int v;
        v = h[i-1][j-1] + (sq[i-1] == tq[j-1] ? 2 : -1);
        if (h[i-1][j] - 1 > v) v = h[i-1][j] - 1;
        if (h[i][j-1] - 1 > v) v = h[i][j-1] - 1;
        if (v < 0) v = 0;
        h[i][j] = v;
        if (v > best) best = v;
      end
      cm[j-1] = best;
    end
  endtask
  task automatic randomize_job(input int tl);
    for (int i = 0; i < N_PE; i++) sq[i] = 2'($urandom);
    for (int j = 0; j < T_MAX; j++) tq[j] = 2'($urandom);
    build_model(tl);
  endtask
  task automatic fill(input int n_beats, input bit use_last, input bit gaps,
                      output int t_acc, output int iters);
    int si = 0;
    bit sa, ta;
    b.start = 1'b1;
    @(posedge clk); #1;
    b.start = 1'b0;
    t_acc = 0;
    iters = 0;
    while ((si < N_PE || b.t_ready) && iters < 300) begin
      b.s_valid = si < N_PE && (!gaps || $urandom_range(0, 2) != 0);
      b.s_data  = si < N_PE ? sq[si] : 2'b00;
      b.t_valid = t_acc < n_beats && (!gaps || $urandom_range(0, 2) != 0);
      b.t_data  = t_acc < T_MAX ? tq[t_acc] : 2'($urandom);
      b.t_last  = use_last && t_acc == n_beats - 1;
      sa = b.s_valid && b.s_ready;
      ta = b.t_valid && b.t_ready;
      @(posedge clk); #1;
      si += int'(sa);
      t_acc += int'(ta);
      iters++;
    end
    b.s_valid = 1'b0;
    b.t_valid = 1'b0;
    b.t_last  = 1'b0;
    vectors++;
    if (iters >= 300) begin
      miscompares++;
      $display("FAIL fill_timeout: s accepted %0d, t accepted %0d after %0d cycles", si, t_acc, iters);
    end
  endtask
  task automatic capture(input int budget, input bit poke);
    int cyc = 0;
    bit load_on = 0;
    cap_s.delete();
    cap_t.delete();
    chg_cnt = 0; first_init = -1; last_init = -1; done_cyc = -1; done_cnt = 0; cap_score = '0;
    while (done_cnt == 0 && cyc < budget) begin
      if (b.arr_changeS) begin chg_cnt++; load_on = 1; end
      if (load_on && cap_s.size() < N_PE) cap_s.push_back(b.arr_S);
      if (b.arr_init) begin
        if (first_init < 0) first_init = cyc;
        last_init = cyc;
        cap_t.push_back(b.arr_T);
      end
      if (b.done) begin
        done_cnt++;
        done_cyc = cyc;
        cap_score = b.score;
      end else begin
        b.start = poke && b.busy && (cyc % 3 == 0);
        @(posedge clk); #1;
        cyc++;
      end
    end
    b.start = 1'b0;
    vectors++;
    if (done_cnt == 0) begin
      miscompares++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask
  task automatic test_reset();
    int ta, it;
    bit saw_done = 0, saw_busy = 0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (b.busy !== 1'b0 || b.done !== 1'b0 || b.score !== '0 || b.arr_init !== 1'b0 ||
        b.arr_changeS !== 1'b0 || b.s_ready !== 1'b0 || b.t_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b score=%0d init=%b chg=%b s_ready=%b t_ready=%b, expected all 0",
               b.busy, b.done, b.score, b.arr_init, b.arr_changeS, b.s_ready, b.t_ready);
    end
    vectors++;
    if (b.arr_F !== 12'h900 || b.arr_MAX !== '0 || b.arr_V !== '0) begin
      miscompares++;
      $display("FAIL reset_consts: F=%h MAX=%h V=%h, expected 900 000 000", b.arr_F, b.arr_MAX, b.arr_V);
    end
    chain_en = 1;
    randomize_job(20);
    fill(20, 1, 0, ta, it);
    it = 0;
    while (!b.arr_init && it < 50) begin @(posedge clk); #1; it++; end
    vectors++;
    if (b.arr_init !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_reach_stream: arr_init=%b, expected 1", b.arr_init);
    end
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (b.busy !== 1'b0 || b.arr_init !== 1'b0 || b.arr_F !== 12'h900 || b.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_stream: busy=%b init=%b F=%h done=%b, expected 0 0 900 0",
               b.busy, b.arr_init, b.arr_F, b.done);
    end
    for (int i = 0; i < 40; i++) begin
      if (b.done) saw_done = 1;
      if (b.busy) saw_busy = 1;
      @(posedge clk); #1;
    end
    vectors++;
    if (saw_done || saw_busy) begin
      miscompares++;
      $display("FAIL reset_abort: done seen=%b busy seen=%b, expected 0 0", saw_done, saw_busy);
    end
  endtask
  task automatic test_load_stream();
    int ta, it, bad = 0;
    logic [1:0] exp_t [3] = '{2'd3, 2'd2, 2'd1};
    chain_en = 1;
    for (int i = 0; i < N_PE; i++) sq[i] = 2'(i % 4);
    for (int j = 0; j < T_MAX; j++) tq[j] = j < 3 ? exp_t[j] : 2'($urandom);
    build_model(3);
    fill(3, 1, 1, ta, it);
    capture(200, 0);
    vectors++;
    if (chg_cnt != 1) begin
      miscompares++;
      $display("FAIL load_changeS_len: high %0d cycles, expected 1", chg_cnt);
    end
    for (int i = 0; i < N_PE; i++) if (i >= cap_s.size() || cap_s[i] !== 2'(i % 4)) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL load_s_seq: %0d of %0d S symbols wrong (got %0d captured)", bad, N_PE, cap_s.size());
    end
    bad = 0;
    for (int j = 0; j < 3; j++) if (j >= cap_t.size() || cap_t[j] !== exp_t[j]) bad++;
    vectors++;
    if (bad != 0 || cap_t.size() != 3 || last_init - first_init != 2) begin
      miscompares++;
      $display("FAIL stream_t_seq: %0d wrong, init cycles=%0d span=%0d, expected 0 3 3",
               bad, cap_t.size(), last_init - first_init + 1);
    end
    vectors++;
    if (done_cyc - first_init != 3 + N_PE + 1 || cap_score !== W'(cm[2])) begin
      miscompares++;
      $display("FAIL load_done: latency=%0d score=%0d, expected %0d %0d",
               done_cyc - first_init, cap_score, 3 + N_PE + 1, cm[2]);
    end
    @(posedge clk); #1;
    vectors++;
    if (b.done !== 1'b0 || b.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b busy=%b one cycle later, expected 0 0", b.done, b.busy);
    end
  endtask
  task automatic test_tail_capture();
    int ta, it;
    bit quiet = 1;
    chain_en = 0;
    m_init = 1'b0;
    randomize_job(2);
    fill(2, 1, 0, ta, it);
    it = 0;
    while (!b.arr_init && it < 40) begin @(posedge clk); #1; it++; end
    while (b.arr_init && it < 60) begin @(posedge clk); #1; it++; end
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (b.busy !== 1'b1 || b.done !== 1'b0) begin
      miscompares++;
      $display("FAIL tail_no_rise: busy=%b done=%b in DRAIN before tail rose, expected 1 0", b.busy, b.done);
    end
    m_init = 1'b1; m_max = 12'd5;
    @(posedge clk); #1; quiet &= !b.done;
    m_max = 12'd9;
    @(posedge clk); #1; quiet &= !b.done;
    m_max = 12'd14;
    @(posedge clk); #1; quiet &= !b.done;
    m_init = 1'b0; m_max = 12'd3;
    @(posedge clk); #1;
    vectors++;
    if (!quiet || b.done !== 1'b1 || b.score !== 12'd14) begin
      miscompares++;
      $display("FAIL tail_capture: quiet=%b done=%b score=%0d, expected 1 1 14", quiet, b.done, b.score);
    end
    @(posedge clk); #1;
    vectors++;
    if (b.done !== 1'b0 || b.busy !== 1'b0 || b.score !== 12'd14) begin
      miscompares++;
      $display("FAIL tail_hold: done=%b busy=%b score=%0d, expected 0 0 14", b.done, b.busy, b.score);
    end
  endtask
  task automatic test_overflow();
    int ta, it, bad = 0;
    chain_en = 1;
    randomize_job(T_MAX);
    fill(70, 0, 1, ta, it);
    vectors++;
    if (ta != T_MAX || b.t_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_accept: accepted %0d t_ready=%b, expected %0d 0", ta, b.t_ready, T_MAX);
    end
    capture(400, 0);
    for (int j = 0; j < T_MAX; j++) if (j >= cap_t.size() || cap_t[j] !== tq[j]) bad++;
    vectors++;
    if (bad != 0 || cap_t.size() != T_MAX || last_init - first_init != T_MAX - 1) begin
      miscompares++;
      $display("FAIL overflow_stream: %0d wrong, length=%0d, expected 0 %0d", bad, cap_t.size(), T_MAX);
    end
    vectors++;
    if (done_cyc - first_init != T_MAX + N_PE + 1 || cap_score !== W'(cm[T_MAX-1])) begin
      miscompares++;
      $display("FAIL overflow_done: latency=%0d score=%0d, expected %0d %0d",
               done_cyc - first_init, cap_score, T_MAX + N_PE + 1, cm[T_MAX-1]);
    end
  endtask
  task automatic test_full_chain();
    int ta, it;
    chain_en = 1;
    for (int i = 0; i < N_PE; i++) begin sq[i] = 2'(i % 4); tq[i] = 2'(i % 4); end
    build_model(N_PE);
    fill(N_PE, 1, 0, ta, it);
    capture(200, 0);
    vectors++;
    if (done_cyc - first_init != 17) begin
      miscompares++;
      $display("FAIL chain_latency: %0d cycles, expected 17", done_cyc - first_init);
    end
    vectors++;
    if (cap_score !== W'(cm[N_PE-1])) begin
      miscompares++;
      $display("FAIL chain_score: %0d, expected %0d", cap_score, cm[N_PE-1]);
    end
  endtask
  task automatic test_concurrency();
    int ta, it;
    bit saw_busy = 0;
    chain_en = 1;
    randomize_job(5);
    fill(5, 1, 0, ta, it);
    vectors++;
    if (it != N_PE || ta != 5) begin
      miscompares++;
      $display("FAIL concurrent_fill: %0d cycles %0d T beats, expected %0d 5", it, ta, N_PE);
    end
    capture(200, 1);
    vectors++;
    if (done_cyc - first_init != 5 + N_PE + 1 || cap_score !== W'(cm[4])) begin
      miscompares++;
      $display("FAIL concurrent_done: latency=%0d score=%0d, expected %0d %0d",
               done_cyc - first_init, cap_score, 5 + N_PE + 1, cm[4]);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (b.busy) saw_busy = 1;
    end
    vectors++;
    if (saw_busy) begin
      miscompares++;
      $display("FAIL start_while_busy: busy after done, expected idle");
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int tl, ta, it, bad;
      bit ul;
      tl = k == 0 ? 1 : $urandom_range(1, T_MAX);
      ul = tl < T_MAX ? 1'b1 : 1'($urandom);
      chain_en = 1;
      randomize_job(tl);
      fill(tl, ul, 1, ta, it);
      capture(400, 0);
      bad = 0;
      for (int i = 0; i < N_PE; i++) if (i >= cap_s.size() || cap_s[i] !== sq[i]) bad++;
      for (int j = 0; j < tl; j++) if (j >= cap_t.size() || cap_t[j] !== tq[j]) bad++;
      vectors++;
      if (bad != 0 || chg_cnt != 1 || cap_t.size() != tl) begin
        miscompares++;
        $display("FAIL random_seq[%0d]: %0d symbols wrong chg=%0d t_len=%0d, expected 0 1 %0d",
                 k, bad, chg_cnt, cap_t.size(), tl);
      end
      vectors++;
      if (done_cyc - first_init != tl + N_PE + 1 || cap_score !== W'(cm[tl-1])) begin
        miscompares++;
        $display("FAIL random_done[%0d]: latency=%0d score=%0d, expected %0d %0d",
                 k, done_cyc - first_init, cap_score, tl + N_PE + 1, cm[tl-1]);
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    b.start = 1'b0; b.s_valid = 1'b0; b.s_data = 2'b00;
    b.t_valid = 1'b0; b.t_data = 2'b00; b.t_last = 1'b0;
    test_reset();
    test_load_stream();
    test_tail_capture();
    test_overflow();
    test_full_chain();
    test_concurrency();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
